// File: rtl/nn_sld_pkg.sv
// Shared encodings, FSM states and config helpers for the sliding-window sequencer.
package nn_sld_pkg;

  localparam logic [1:0] MODE_3X3 = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PRIME,
    S_WAIT,
    S_SLIDE,
    S_DONE
  } state_t;

  // Kernel width in columns: 3 for the 3x3 mode, 6 for every other mode.
  function automatic logic [2:0] kernel_w(input logic [1:0] mode);
    return (mode == MODE_3X3) ? 3'd3 : 3'd6;
  endfunction

  // A stride of zero behaves as a stride of one.
  function automatic logic [1:0] norm_stride(input logic [1:0] stride);
    return (stride == 2'd0) ? 2'd1 : stride;
  endfunction

endpackage

// File: rtl/nn_sld_ctrl_if.sv
// Config, activation-buffer, register-file and PE handshake bundle of the sliding-window sequencer.
interface nn_sld_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 6,
  parameter int COL_W      = 8,
  parameter int BAND_W     = 6
);
  localparam int TOTAL_DATA_WIDTH = DATA_WIDTH * ROW_NUM;

  logic                        i_start;
  logic [1:0]                  i_mode;
  logic                        i_half;
  logic [1:0]                  i_stride;
  logic [COL_W-1:0]            i_img_w;
  logic [BAND_W-1:0]           i_bands;
  logic                        o_rd_en;
  logic [BAND_W+COL_W-1:0]     o_rd_addr;
  logic [TOTAL_DATA_WIDTH-1:0] i_rd_data;
  logic [TOTAL_DATA_WIDTH-1:0] o_sld_data;
  logic                        o_sld_shift;
  logic [1:0]                  o_sld_mode;
  logic                        o_sld_3x3;
  logic                        o_win_valid;
  logic                        i_win_ready;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_err;

  modport master (
    input  i_start, i_mode, i_half, i_stride, i_img_w, i_bands, i_rd_data, i_win_ready,
    output o_rd_en, o_rd_addr, o_sld_data, o_sld_shift, o_sld_mode, o_sld_3x3,
           o_win_valid, o_busy, o_done, o_err
  );

  modport slave (
    output i_start, i_mode, i_half, i_stride, i_img_w, i_bands, i_rd_data, i_win_ready,
    input  o_rd_en, o_rd_addr, o_sld_data, o_sld_shift, o_sld_mode, o_sld_3x3,
           o_win_valid, o_busy, o_done, o_err
  );

endinterface

// File: rtl/nn_sld_addr_gen.sv
// Band/column counters for the activation-buffer read address plus end-of-row and last-band flags.
module nn_sld_addr_gen
  import nn_sld_pkg::*;
#(
  parameter int COL_W  = 8,
  parameter int BAND_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    col_inc,
  input  logic                    band_inc,
  input  logic [1:0]              stride,
  input  logic [COL_W-1:0]        img_w,
  input  logic [BAND_W-1:0]       bands,
  output logic [BAND_W+COL_W-1:0] addr,
  output logic                    slide_ok,
  output logic                    last_band
);

  localparam int CW1 = COL_W + 1;
  localparam int BW1 = BAND_W + 1;

  logic [COL_W-1:0]  col_reg;
  logic [BAND_W-1:0] band_reg;
  logic [CW1-1:0]    col_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg  <= '0;
      band_reg <= '0;
    end else if (clr) begin
      col_reg  <= '0;
      band_reg <= '0;
    end else if (band_inc) begin
      band_reg <= band_reg + BAND_W'(1);
      col_reg  <= '0;
    end else if (col_inc) begin
      col_reg  <= col_reg + COL_W'(1);
    end
  end

  // One extra bit so a full-width image never wraps the end-of-row test.
  assign col_end   = {1'b0, col_reg} + CW1'(norm_stride(stride));
  assign slide_ok  = (col_end <= {1'b0, img_w});
  assign last_band = (({1'b0, band_reg} + BW1'(1)) >= {1'b0, bands});
  assign addr      = {band_reg, col_reg};

endmodule

// File: rtl/nn_sld_ctrl.sv
// Sliding-window sequencer: primes and slides the RF from the activation buffer and hands each
// complete window to the PE array, band by band.
module nn_sld_ctrl
  import nn_sld_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 6,
  parameter int COL_W      = 8,
  parameter int BAND_W     = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  nn_sld_ctrl_if.master bus
);

  state_t            state_reg;
  logic [1:0]        mode_reg;
  logic [1:0]        stride_reg;
  logic [COL_W-1:0]  img_w_reg;
  logic [BAND_W-1:0] bands_reg;
  logic [2:0]        k_reg;
  logic [2:0]        cnt_reg;
  logic              sld_3x3_reg;
  logic              rd_en_reg;
  logic              shift_reg;
  logic              pend_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic              cfg_bad;
  logic              burst_last;
  logic              handshake;
  logic              band_inc;
  logic              slide_ok;
  logic              last_band;

  assign cfg_bad    = (img_w_reg < COL_W'(k_reg)) || (bands_reg == '0);
  assign burst_last = (state_reg == S_PRIME) ? (cnt_reg == k_reg - 3'd1)
                                             : (cnt_reg == {1'b0, stride_reg} - 3'd1);
  assign handshake  = (state_reg == S_WAIT) && valid_reg && bus.i_win_ready;
  assign band_inc   = handshake && !slide_ok && !last_band;

  nn_sld_addr_gen #(
    .COL_W  (COL_W),
    .BAND_W (BAND_W)
  ) u_addr_gen (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .clr       (state_reg == S_CHECK),
    .col_inc   (rd_en_reg),
    .band_inc  (band_inc),
    .stride    (stride_reg),
    .img_w     (img_w_reg),
    .bands     (bands_reg),
    .addr      (bus.o_rd_addr),
    .slide_ok  (slide_ok),
    .last_band (last_band)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg   <= S_IDLE;
      mode_reg    <= '0;
      stride_reg  <= '0;
      img_w_reg   <= '0;
      bands_reg   <= '0;
      k_reg       <= '0;
      cnt_reg     <= '0;
      sld_3x3_reg <= 1'b0;
      rd_en_reg   <= 1'b0;
      shift_reg   <= 1'b0;
      pend_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      // Read data arrives one cycle after the strobe and is shifted straight into the RF.
      shift_reg <= rd_en_reg;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.i_start) begin
            mode_reg    <= bus.i_mode;
            stride_reg  <= norm_stride(bus.i_stride);
            img_w_reg   <= bus.i_img_w;
            bands_reg   <= bus.i_bands;
            k_reg       <= kernel_w(bus.i_mode);
            sld_3x3_reg <= (bus.i_mode == MODE_3X3) && bus.i_half;
            busy_reg    <= 1'b1;
            state_reg   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_DONE;
          end else begin
            cnt_reg   <= '0;
            rd_en_reg <= 1'b1;
            state_reg <= S_PRIME;
          end
        end
        S_PRIME, S_SLIDE: begin
          if (burst_last) begin
            rd_en_reg <= 1'b0;
            pend_reg  <= 1'b1;
            state_reg <= S_WAIT;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        S_WAIT: begin
          // pend_reg covers the cycle in which the last shift is still landing in the RF.
          if (pend_reg) begin
            pend_reg  <= 1'b0;
            valid_reg <= 1'b1;
          end else if (handshake) begin
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            if (slide_ok) begin
              rd_en_reg <= 1'b1;
              state_reg <= S_SLIDE;
            end else if (!last_band) begin
              rd_en_reg <= 1'b1;
              state_reg <= S_PRIME;
            end else begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_pix
    assign bus.o_sld_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      shift_reg ? bus.i_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign bus.o_rd_en       = rd_en_reg;
  assign bus.o_sld_shift   = shift_reg;
  assign bus.o_sld_mode    = mode_reg;
  assign bus.o_sld_3x3     = sld_3x3_reg;
  assign bus.o_win_valid   = valid_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_done        = done_reg;
  assign bus.o_err         = err_reg;

endmodule

// File: tb/tb_nn_sld_ctrl.sv
// Scoreboard bench for nn_sld_ctrl: expected reads/shifts queued per pass, matched as the DUT emits them.
module tb_nn_sld_ctrl;

  localparam int DW  = 8;
  localparam int RN  = 6;
  localparam int CW  = 8;
  localparam int BW  = 6;
  localparam int TDW = DW * RN;
  localparam int AW  = BW + CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nn_sld_ctrl_if #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_W(CW), .BAND_W(BW)) bus ();

  nn_sld_ctrl #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_W(CW), .BAND_W(BW)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  logic [AW-1:0]  addr_q[$];
  logic [TDW-1:0] data_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  win_cnt, done_cnt, err_cnt, rd_cnt;
  int  exp_wins;
  bit  exp_err;
  bit  mon_en = 1'b0;
  logic [1:0] exp_mode;
  logic       exp_3x3;

  function automatic logic [TDW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 14'h2a5, a, a + 14'd17, 6'h2b};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Activation buffer: one-cycle read latency, all-ones when idle so ungated data would show.
  always @(posedge clk)
    bus.i_rd_data <= bus.o_rd_en ? mem_word(bus.o_rd_addr) : {TDW{1'b1}};

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_rd_en) begin
        rd_cnt++;
        check_val("rd_while_valid", 64'(bus.o_win_valid), 64'(0));
        check_val("rd_expected", 64'(addr_q.size() != 0), 64'(1));
        if (addr_q.size() != 0) check_val("rd_addr", 64'(bus.o_rd_addr), 64'(addr_q.pop_front()));
      end
      if (bus.o_sld_shift) begin
        check_val("shift_expected", 64'(data_q.size() != 0), 64'(1));
        if (data_q.size() != 0) check_val("sld_data", 64'(bus.o_sld_data), 64'(data_q.pop_front()));
        check_val("sld_mode", 64'(bus.o_sld_mode), 64'(exp_mode));
        check_val("sld_3x3", 64'(bus.o_sld_3x3), 64'(exp_3x3));
      end else begin
        check_val("sld_data_idle", 64'(bus.o_sld_data), 64'(0));
      end
      if (bus.o_win_valid && bus.i_win_ready) win_cnt++;
      if (bus.o_done) begin
        done_cnt++;
        if (bus.o_err) err_cnt++;
        check_val("busy_at_done", 64'(bus.o_busy), 64'(0));
      end else begin
        check_val("err_without_done", 64'(bus.o_err), 64'(0));
      end
    end
  end

  // Reference walk of a layer pass, straight from the sequencing rules.
  task automatic model_pass(input logic [1:0] mode, input logic [1:0] stride,
                            input int img_w, input int bands);
    int k, s, col;
    logic [AW-1:0] a;
    k = (mode == 2'b00) ? 3 : 6;
    s = (stride == 2'd0) ? 1 : int'(stride);
    exp_wins = 0;
    exp_err = (img_w < k) || (bands == 0);
    if (!exp_err) begin
      for (int b = 0; b < bands; b++) begin
        col = 0;
        for (int i = 0; i < k; i++) begin
          a = AW'((b << CW) | col);
          addr_q.push_back(a);
          data_q.push_back(mem_word(a));
          col++;
        end
        exp_wins++;
        while (col + s <= img_w) begin
          for (int i = 0; i < s; i++) begin
            a = AW'((b << CW) | col);
            addr_q.push_back(a);
            data_q.push_back(mem_word(a));
            col++;
          end
          exp_wins++;
        end
      end
    end
  endtask

  task automatic start_pass(input logic [1:0] mode, input logic half, input logic [1:0] stride,
                            input int img_w, input int bands, input logic ready);
    model_pass(mode, stride, img_w, bands);
    exp_mode = mode;
    exp_3x3  = (mode == 2'b00) ? half : 1'b0;
    win_cnt = 0; done_cnt = 0; err_cnt = 0; rd_cnt = 0;
    @(posedge clk); #1;
    bus.i_mode = mode; bus.i_half = half; bus.i_stride = stride;
    bus.i_img_w = CW'(img_w); bus.i_bands = BW'(bands);
    bus.i_win_ready = ready;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check_val("busy_after_start", 64'(bus.o_busy), 64'(1));
    // Config must be latched; disturb the inputs for the rest of the pass.
    bus.i_mode = ~mode; bus.i_half = ~half; bus.i_stride = stride + 2'd1;
    bus.i_img_w = CW'(img_w ^ 3); bus.i_bands = BW'(bands + 1);
  endtask

  task automatic finish_pass(input string name);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      @(posedge clk); #2;
    end
    check_val({name, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
    #2;
    check_val({name, "_done_once"}, 64'(done_cnt), 64'(1));
    check_val({name, "_err"}, 64'(err_cnt), 64'(exp_err));
    check_val({name, "_windows"}, 64'(win_cnt), 64'(exp_wins));
    check_val({name, "_reads_left"}, 64'(addr_q.size()), 64'(0));
    check_val({name, "_shifts_left"}, 64'(data_q.size()), 64'(0));
    check_val({name, "_busy_idle"}, 64'(bus.o_busy), 64'(0));
    $display("pass %s: reads=%0d windows=%0d done=%0d err=%0d", name, rd_cnt, win_cnt, done_cnt, err_cnt);
  endtask

  task automatic check_outs_zero(input string tag);
    check_val(tag, 64'({bus.o_rd_en, bus.o_sld_shift, bus.o_win_valid, bus.o_busy, bus.o_done,
                        bus.o_err, bus.o_sld_3x3, bus.o_sld_mode, bus.o_rd_addr}), 64'(0));
    check_val({tag, "_data"}, 64'(bus.o_sld_data), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_mode = 2'b00; bus.i_half = 1'b0; bus.i_stride = 2'd0;
    bus.i_img_w = '0; bus.i_bands = '0; bus.i_win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset_state");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 3 windows, addresses 0..7
    start_pass(2'b01, 1'b0, 2'd1, 8, 1, 1'b1);
    finish_pass("k6_s1_w8");

    // 3x3 with half select, stride 2
    start_pass(2'b00, 1'b1, 2'd2, 7, 1, 1'b1);
    finish_pass("k3_s2_w7");

    // two bands, stride 3, last column never read
    start_pass(2'b01, 1'b0, 2'd3, 10, 2, 1'b1);
    finish_pass("k6_s3_w10_b2");

    // stride 0 treated as 1
    start_pass(2'b00, 1'b0, 2'd0, 5, 2, 1'b1);
    finish_pass("k3_s0_w5_b2");

    // backpressure: window held, no reads while stalled
    start_pass(2'b01, 1'b0, 2'd1, 8, 1, 1'b0);
    for (int i = 0; i < 100 && !bus.o_win_valid; i++) begin
      @(posedge clk); #1;
    end
    check_val("valid_rise", 64'(bus.o_win_valid), 64'(1));
    repeat (20) begin
      @(posedge clk); #1;
      check_val("valid_held", 64'(bus.o_win_valid), 64'(1));
      check_val("no_rd_stall", 64'({bus.o_rd_en, bus.o_sld_shift}), 64'(0));
    end
    bus.i_win_ready = 1'b1;
    finish_pass("stall20");

    // bad configurations
    start_pass(2'b01, 1'b0, 2'd1, 4, 1, 1'b1);
    finish_pass("narrow_img");
    start_pass(2'b00, 1'b0, 2'd1, 8, 0, 1'b1);
    finish_pass("zero_bands");

    // abort mid-slide, ignoring a start issued while busy
    start_pass(2'b01, 1'b0, 2'd3, 10, 2, 1'b1);
    for (int i = 0; i < 200 && rd_cnt < 3; i++) begin
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_mode = 2'b00;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check_val("mode_kept_busy", 64'(bus.o_sld_mode), 64'(2'b01));
    for (int i = 0; i < 200 && rd_cnt < 7; i++) begin
      @(posedge clk); #2;
    end
    check_val("reached_slide", 64'(rd_cnt >= 7), 64'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outs_zero("abort_outs");
    repeat (3) begin
      @(posedge clk); #1;
      check_val("abort_quiet", 64'({bus.o_rd_en, bus.o_sld_shift, bus.o_busy}), 64'(0));
    end
    addr_q.delete();
    data_q.delete();
    rst_n = 1'b1;
    mon_en = 1'b1;
    start_pass(2'b01, 1'b0, 2'd3, 10, 2, 1'b1);
    finish_pass("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
